// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the prefetching fetch unit
package fetch_pkg;
  localparam logic [31:0] FETCH_INT_INST = 32'hA7C00000;
  typedef enum logic [1:0] {INT_NONE = 2'b00, INT0 = 2'b01, INT1 = 2'b10} int_code_t;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush (flush beats push), push on full legal with pop
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int W = $bits(fetch_entry_t),
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd];
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      wr <= wr + AW'(do_push);
      rd <= rd + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  // storage, left unreset since reads are masked by empty
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr] <= din;
endmodule

// File: rtl/fetch_pq.sv
// fetch_pq: prefetching fetch queue with redirect drop and interrupt injection (FETCH_INT_EN)
module fetch_pq
  import fetch_pkg::*;
#(
  parameter int N = 32,
  parameter int DEPTH = 4,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_pc,
  input  logic         halt,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [N-1:0] imem_rdata,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_inst,
  output logic [N-1:0] out_pc,
  input  logic [1:0]   interrupt,
  output logic [1:0]   out_inter
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [N-1:0] fetch_pc, resp_pc, head_inst, head_pc;
  logic [CW-1:0] outstanding, drop_cnt, count;
  logic empty, full, push, pop, issued, drop;
  assign imem_req = !rst && !halt && !redirect_valid &&
                    (({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;
  assign issued = imem_req && imem_gnt;
  assign drop = redirect_valid || drop_cnt != '0;
  assign push = imem_rvalid && !drop;
  fetch_fifo #(.W(2*N), .DEPTH(DEPTH)) u_q (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(redirect_valid),
    .din({imem_rdata, resp_pc}), .dout({head_inst, head_pc}),
    .full(full), .empty(empty), .count(count)
  );
  // fetch/response PCs and in-flight credit; resp_pc tracks the next accepted response
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
    end else begin
      fetch_pc <= redirect_valid ? redirect_pc : fetch_pc + N'(issued ? 4 : 0);
      resp_pc <= redirect_valid ? redirect_pc : resp_pc + N'(push ? 4 : 0);
      outstanding <= outstanding + CW'(issued) - CW'(imem_rvalid);
      drop_cnt <= redirect_valid ? outstanding - CW'(imem_rvalid)
                                 : drop_cnt - CW'(imem_rvalid && drop_cnt != '0);
    end
`ifdef FETCH_INT_EN
  logic int_pend;
  int_code_t int_code;
  // interrupt latch: first nonzero request wins until its trap is handed to decode
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      int_pend <= 1'b0;
      int_code <= INT_NONE;
    end else if (int_pend) begin
      if (out_ready) int_pend <= 1'b0;
    end else if (|interrupt) begin
      int_pend <= 1'b1;
      int_code <= interrupt[1] ? INT1 : INT0;
    end
  assign out_valid = !empty || int_pend;
  assign pop = out_ready && !int_pend;
  assign out_inst = int_pend ? N'(FETCH_INT_INST) : (empty ? '0 : head_inst);
  assign out_pc = empty ? (int_pend ? fetch_pc : '0) : head_pc;
  assign out_inter = int_pend ? int_code : INT_NONE;
`else
  logic unused_int;
  assign unused_int = ^interrupt;
  assign out_valid = !empty;
  assign pop = out_ready;
  assign out_inst = empty ? '0 : head_inst;
  assign out_pc = empty ? '0 : head_pc;
  assign out_inter = 2'b00;
`endif
endmodule

// File: tb/tb_fetch_pq.sv
// tb_fetch_pq: self-checking bench for fetch_pq with a latency-configurable memory and PC scoreboard
module tb_fetch_pq;
  import fetch_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, redirect_valid = 0, halt = 0, imem_gnt = 1, imem_rvalid = 0, out_ready = 0;
  logic [31:0] redirect_pc = '0, imem_rdata = '0;
  logic [1:0] interrupt = '0;
  logic imem_req, out_valid;
  logic [31:0] imem_addr, out_inst, out_pc;
  logic [1:0] out_inter;
  fetch_pq #(.N(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .interrupt(interrupt), .out_inter(out_inter)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rdy; logic hlt; logic req; logic [31:0] addr; logic vld; logic [31:0] pc;
  } vec_t;
  vec_t tbl[11];
  int pass = 0, total = 0, cyc = 0, lat = 1;
  logic [31:0] exp_q[$], seen[$], mq_addr[$], last_grant = '0, head = '0, stall_pc = '0;
  int mq_due[$];
  logic int_exp = 0;
  logic [1:0] int_code_exp = '0;
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h3C00_0013;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask
  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (int_exp) begin
          chk("int_hs_inst", out_inst, FETCH_INT_INST);
          chk("int_hs_code", 32'(out_inter), 32'(int_code_exp));
          int_exp = 0;
        end else if (exp_q.size() == 0) begin
          total++;
          $display("FAIL hs_unexpected: got pc %h expected no handshake", out_pc);
        end else begin
          head = exp_q.pop_front();
          chk("hs_pc", out_pc, head);
          chk("hs_inst", out_inst, inst_of(head));
          chk("hs_inter", 32'(out_inter), 32'h0);
          seen.push_back(out_pc);
        end
      end
      if (redirect_valid) exp_q.delete();
      if (imem_req && imem_gnt) begin
        exp_q.push_back(imem_addr);
        mq_addr.push_back(imem_addr);
        mq_due.push_back(cyc + lat);
        last_grant = imem_addr;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      imem_rvalid = 1;
      imem_rdata = inst_of(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      imem_rvalid = 0;
      imem_rdata = '0;
    end
  endtask
  task automatic drain();
    halt = 1;
    out_ready = 1;
    for (int i = 0; i < 40 && (exp_q.size() != 0 || mq_due.size() != 0); i++) tick();
    chk("drain_empty", 32'(exp_q.size() + mq_due.size()), 32'h0);
  endtask
  task automatic wait_seen(input int n);
    for (int i = 0; i < 30 && seen.size() < n; i++) tick();
    chk("seen_count", 32'(seen.size() >= n), 32'h1);
  endtask
  initial begin
    tbl[0]  = '{1, 0, 1, 32'h00, 0, 32'h00};
    tbl[1]  = '{1, 0, 1, 32'h04, 0, 32'h00};
    tbl[2]  = '{1, 0, 1, 32'h08, 1, 32'h00};
    tbl[3]  = '{1, 0, 1, 32'h0C, 1, 32'h04};
    tbl[4]  = '{1, 0, 1, 32'h10, 1, 32'h08};
    tbl[5]  = '{1, 1, 0, 32'h14, 1, 32'h0C};
    tbl[6]  = '{1, 1, 0, 32'h14, 1, 32'h10};
    tbl[7]  = '{1, 1, 0, 32'h14, 0, 32'h00};
    tbl[8]  = '{1, 0, 1, 32'h14, 0, 32'h00};
    tbl[9]  = '{1, 0, 1, 32'h18, 0, 32'h00};
    tbl[10] = '{1, 0, 1, 32'h1C, 1, 32'h14};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_inst", out_inst, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_inter", 32'(out_inter), 32'h0);
    rst = 0;
    cyc = 0;
    for (int i = 0; i < 11; i++) begin
      out_ready = tbl[i].rdy;
      halt = tbl[i].hlt;
      #1;
      chk($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_pc", i), out_pc, tbl[i].pc);
      tick();
    end
    out_ready = 0;
    #1 stall_pc = out_pc;
    repeat (10) tick();
    chk("bp_req_off", 32'(imem_req), 32'h0);
    chk("bp_inflight", 32'(exp_q.size()), 32'(DEPTH));
    chk("bp_valid_held", 32'(out_valid), 32'h1);
    chk("bp_pc_held", out_pc, stall_pc);
    halt = 1;
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("halt_req", 32'(imem_req), 32'h0);
      tick();
    end
    chk("halt_drained", 32'(exp_q.size()), 32'h0);
    chk("halt_valid", 32'(out_valid), 32'h0);
    halt = 0;
    #1;
    chk("resume_req", 32'(imem_req), 32'h1);
    chk("resume_addr", imem_addr, last_grant + 32'h4);
    drain();
    lat = 3;
    halt = 0;
    tick();
    tick();
    redirect_valid = 1;
    redirect_pc = 32'h100;
    seen.delete();
    #1 chk("redir_noreq", 32'(imem_req), 32'h0);
    tick();
    redirect_valid = 0;
    #1;
    chk("redir_valid_t1", 32'(out_valid), 32'h0);
    chk("redir_req_t1", 32'(imem_req), 32'h1);
    chk("redir_addr_t1", imem_addr, 32'h100);
    wait_seen(2);
    if (seen.size() >= 2) begin
      chk("redir_first", seen[0], 32'h100);
      chk("redir_second", seen[1], 32'h104);
    end
    drain();
    lat = 1;
`ifdef FETCH_INT_EN
    halt = 0;
    out_ready = 0;
    repeat (6) tick();
    head = exp_q[0];
    interrupt = 2'b11;
    tick();
    interrupt = 2'b01;
    int_exp = 1;
    int_code_exp = 2'b10;
    #1;
    chk("int_valid", 32'(out_valid), 32'h1);
    chk("int_inst", out_inst, FETCH_INT_INST);
    chk("int_pc", out_pc, head);
    chk("int_code", 32'(out_inter), 32'h2);
    tick();
    interrupt = 2'b00;
    #1 chk("int_code_held", 32'(out_inter), 32'h2);
    out_ready = 1;
    tick();
    out_ready = 0;
    #1;
    chk("post_int_pc", out_pc, head);
    chk("post_int_inst", out_inst, inst_of(head));
    chk("post_int_inter", 32'(out_inter), 32'h0);
    drain();
`endif
    halt = 0;
    out_ready = 0;
    repeat (8) tick();
    chk("pre_rst_valid", 32'(out_valid), 32'h1);
    rst = 1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_req", 32'(imem_req), 32'h0);
    chk("mid_rst_pc", out_pc, 32'h0);
    exp_q.delete();
    mq_addr.delete();
    mq_due.delete();
    imem_rvalid = 0;
    tick();
    tick();
    rst = 0;
    seen.delete();
    #1;
    chk("restart_req", 32'(imem_req), 32'h1);
    chk("restart_addr", imem_addr, 32'h0);
    out_ready = 1;
    wait_seen(1);
    if (seen.size() >= 1) chk("restart_first", seen[0], 32'h0);
    drain();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/fetch_pq.md
# fetch_pq

Prefetching instruction-fetch unit for the pipelined CPU, sitting between the instruction memory port and the IF/DE pipeline register.
- Keeps up to DEPTH fetched instructions plus in-flight memory requests.
- Presents one instruction per cycle to decode over a valid/ready handshake.
- Handles branch redirects by flushing the queue and discarding stale in-flight responses.
- Injects the interrupt trap instruction at the decode boundary.

## Interface
Parameters:
- N, 32: instruction and PC width.
- DEPTH, 4: instruction queue entries. Must be a power of two, ≥2.
- RESET_PC, 32'h0: PC loaded on reset.

Ports:
- clk  in  1: clock; all state on rising edge.
- rst  in  1: asynchronous, active-high reset.
- redirect_valid  in  1: branch/flush redirect from execute.
- redirect_pc  in  N: target PC, word aligned.
- halt  in  1: stop issuing new fetches.
- imem_req  out  1: fetch request.
- imem_addr  out  N: byte address of request, always word aligned.
- imem_gnt  in  1: request accepted this cycle.
- imem_rvalid  in  1: response valid. Responses return in order, latency ≥1 cycle.
- imem_rdata  in  N: fetched instruction.
- out_valid  out  1: instruction available to decode.
- out_ready  in  1: decode accepts.
- out_inst  out  N: instruction.
- out_pc  out  N: PC of out_inst.
- interrupt  in  2: interrupt request lines; bit 1 has priority.
- out_inter  out  2: interrupt code attached to the current output.

## Operation
- fetch_pc register:
  - Reset to RESET_PC.
  - Increments by 4 on each imem_req && imem_gnt.
  - Loaded with redirect_pc on redirect.
- Issue rule: imem_req = !halt && !redirect_valid && (count + outstanding < DEPTH).
  - count is queue occupancy; outstanding is granted-but-unreturned requests.
  - This credit scheme guarantees every response has a free queue slot. The queue never overflows.
- Each queue entry holds {inst, pc}. The pc is taken from a pc FIFO of in-flight addresses, or equivalently from a pc counter in step with responses.
- Response handling:
  - If drop_cnt > 0, the response is discarded and drop_cnt decrements.
  - Otherwise the response is pushed into the queue.
- Redirect in cycle t:
  - Any out handshake in t completes normally.
  - The queue is emptied.
  - drop_cnt is set to (outstanding − responses accepted-and-dropped in t). Responses arriving in t are discarded.
  - fetch_pc is set to redirect_pc.
  - No request is issued in t.
- Halt:
  - No new requests are issued.
  - Outstanding responses still land.
  - The queue drains normally.
  - Deasserting halt resumes fetching from fetch_pc.
- Output:
  - out_valid = queue not empty, or interrupt pending.
  - Pop occurs on out_valid && out_ready, except for interrupt injection.
- Interrupt injection, when compiled in:
  - A nonzero interrupt latches int_pend and int_code; bit 1 wins.
  - While int_pend is set, out_inst = FETCH_INT_INST and out_pc = PC of the queue head, or fetch_pc if the queue is empty.
  - out_inter = int_code, and the queue is not popped.
  - On handshake, int_pend clears.
  - A redirect does not clear int_pend.
  - New interrupts are ignored while int_pend is set.
- Simultaneous push and pop on a full queue is legal. Occupancy is unchanged.

## Timing
- Reset values:
  - imem_req = 0 while reset is held. First request is in the cycle after release, with addr = RESET_PC.
  - out_valid = 0, out_inst = 0, out_pc = 0, out_inter = 0.
  - count = 0, outstanding = 0, drop_cnt = 0, int_pend = 0.
- Response to output latency: imem_rvalid in cycle t gives out_valid in t+1 (registered queue). No combinational path from imem_rdata to out_inst.
- Redirect latency:
  - out_valid is low in t+1, unless an interrupt is pending.
  - imem_req with addr = redirect_pc is issued in t+1.
  - With 1-cycle memory, the first redirected instruction reaches the output in t+3.
- Throughput: one instruction per cycle sustained when memory grants every cycle, latency is 1, and out_ready = 1.
- out_valid, out_inst and out_pc are held stable while out_valid && !out_ready, except when a redirect flushes them.
- Reset asserted mid-operation clears all state asynchronously. Responses to requests made before reset arrive with outstanding = 0 and drop_cnt = 0, so the memory must also be reset alongside.

## Configuration
- FETCH_INT_EN defined: interrupt latch and injection as described.
- FETCH_INT_EN undefined:
  - interrupt is ignored.
  - out_inter is tied to 2'b00.
  - out_valid depends only on the queue.
  - No int_pend state is synthesized.

## Structure
- Package fetch_pkg:
  - FETCH_INT_INST = 32'hA7C00000.
  - typedef int_code_t (2-bit: NONE, INT0, INT1).
  - typedef fetch_entry_t {inst, pc}.
- Sub-module fetch_fifo: synchronous FIFO parametrised on entry type/width and DEPTH.
  - Ports: push, pop, flush, full, empty, count.
  - flush has priority over push.
- fetch_pq holds: fetch_pc, outstanding/drop counters, pc FIFO, interrupt latch, issue logic.

## Test plan
- Reset release, 1-cycle memory, out_ready = 1 → requests at 0x0, 0x4, 0x8…; out_pc 0x0 first seen in cycle 2; one instruction/cycle thereafter.
- out_ready = 0 for 10 cycles, DEPTH = 4 → imem_req drops once count + outstanding = 4; no entry lost; release delivers PCs in order.
- 3-cycle memory latency, redirect to 0x100 with 2 requests outstanding → both stale responses dropped; next out_pc = 0x100, then 0x104.
- halt = 1 for 5 cycles → no imem_req; queued instructions drain; resume continues at the next sequential PC.
- FETCH_INT_EN, interrupt = 2'b11 with head PC 0x20 → out_inst = 0xA7C00000, out_pc = 0x20, out_inter = 2'b10; next handshake delivers the original 0x20 instruction with out_inter = 0.
- Reset asserted mid-stream with a full queue → out_valid = 0 immediately; fetch restarts at RESET_PC.
